// File: rtl/mmc_pkg.sv
// Shared types and constants for the MMC controller: response receiver state
// encoding, frame lengths and the CRC7 polynomial.
package mmc_pkg;
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_RECV       = 2'd2,
    ST_FINISH     = 2'd3
  } rx_state_e;

  localparam int          RSP_SHORT_BITS = 48;
  localparam int          RSP_LONG_BITS  = 136;
  localparam logic [6:0]  CRC7_POLY      = 7'h09;
  localparam int          NCR_DEFAULT    = 64;

  function automatic logic [6:0] crc7_step(logic [6:0] crc, logic b);
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction
endpackage

// File: rtl/mmc_rsp_rx_if.sv
// Control/data bundle between the MMC controller core and the response receiver.
interface mmc_rsp_rx_if;
  logic       start;
  logic       long_rsp;
  logic       crc_en;
  logic       bit_strobe;
  logic       cmd_i;
  logic       busy;
  logic [7:0] byte_data;
  logic       byte_vld;
  logic       rsp_done;
  logic       timeout;
  logic       crc_err;
  logic       frame_err;

  modport master (
    output start, long_rsp, crc_en, bit_strobe, cmd_i,
    input  busy, byte_data, byte_vld, rsp_done, timeout, crc_err, frame_err
  );
  modport slave (
    input  start, long_rsp, crc_en, bit_strobe, cmd_i,
    output busy, byte_data, byte_vld, rsp_done, timeout, crc_err, frame_err
  );
endinterface

// File: rtl/mmc_crc7.sv
// Serial CRC7 (x^7+x^3+1) accumulator; also used by the command transmitter.
module mmc_crc7
  import mmc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);
  logic [6:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr)     crc_d = 7'h00;
    else if (en) crc_d = crc7_step(crc_q, din);
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= 7'h00;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;
endmodule

// File: rtl/mmc_rsp_rx.sv
// MMC/SD response receiver: hunts the start bit within NCR, shifts in an R1..R7
// (48-bit) or R2 (136-bit) frame, streams bytes and checks CRC7/end/transmission bits.
module mmc_rsp_rx
  import mmc_pkg::*;
#(
  parameter int NCR_MAX = NCR_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  mmc_rsp_rx_if.slave  bus
);
  localparam logic [7:0] NCR_LIM = 8'(NCR_MAX);

  rx_state_e  state_q, state_d;
  logic [7:0] ncr_q, ncr_d;
  logic [7:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_vld_q, byte_vld_d;
  logic       long_q, long_d;
  logic       crcen_q, crcen_d;
  logic       timeout_q, timeout_d;
  logic       crc_err_q, crc_err_d;
  logic       frame_err_q, frame_err_d;

  logic       crc_clr, crc_upd, shift;
  logic [6:0] crc;
  logic [7:0] cnt_nxt, last_cnt;

  mmc_crc7 u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_upd),
    .din (bus.cmd_i),
    .crc (crc)
  );

  always_comb begin
    state_d     = state_q;
    ncr_d       = ncr_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    byte_data_d = byte_data_q;
    byte_vld_d  = 1'b0;
    long_d      = long_q;
    crcen_d     = crcen_q;
    timeout_d   = timeout_q;
    crc_err_d   = crc_err_q;
    frame_err_d = frame_err_q;
    crc_clr     = 1'b0;
    crc_upd     = 1'b0;

    // cnt_nxt is the 1-based index of the bit being sampled; frame bit = last_cnt - cnt_nxt
    cnt_nxt  = (state_q == ST_WAIT_START) ? 8'd1 : bit_cnt_q + 8'd1;
    last_cnt = long_q ? 8'(RSP_LONG_BITS) : 8'(RSP_SHORT_BITS);
    shift    = bus.bit_strobe &&
               (((state_q == ST_WAIT_START) && !bus.cmd_i) || (state_q == ST_RECV));

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_WAIT_START;
          timeout_d   = 1'b0;
          crc_err_d   = 1'b0;
          frame_err_d = 1'b0;
          long_d      = bus.long_rsp;
          crcen_d     = bus.crc_en;
          ncr_d       = 8'd0;
          bit_cnt_d   = 8'd0;
          sr_d        = 8'd0;
          crc_clr     = 1'b1;
        end
      end
      ST_WAIT_START: begin
        if (bus.bit_strobe) begin
          if (!bus.cmd_i) begin
            state_d   = ST_RECV;
            bit_cnt_d = 8'd1;
          end else begin
            ncr_d = ncr_q + 8'd1;
            if (ncr_q + 8'd1 == NCR_LIM) begin
              state_d   = ST_FINISH;
              timeout_d = 1'b1;
            end
          end
        end
      end
      ST_RECV: begin
        if (bus.bit_strobe) begin
          bit_cnt_d = cnt_nxt;
          // transmission bit is the second bit of either frame length
          if (cnt_nxt == 8'd2 && bus.cmd_i) frame_err_d = 1'b1;
          if (cnt_nxt == last_cnt) begin
            state_d = ST_FINISH;
            if (!bus.cmd_i) frame_err_d = 1'b1;
            // sr_q[6:0] holds frame bits 7..1 when the end bit arrives
            if (crcen_q && (crc != sr_q[6:0])) crc_err_d = 1'b1;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (shift) begin
      sr_d    = {sr_q[6:0], bus.cmd_i};
      crc_upd = long_q ? (cnt_nxt >= 8'd9 && cnt_nxt <= 8'd128) : (cnt_nxt <= 8'd40);
      if (cnt_nxt[2:0] == 3'd0) begin
        byte_data_d = {sr_q[6:0], bus.cmd_i};
        byte_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ncr_q       <= 8'd0;
      bit_cnt_q   <= 8'd0;
      sr_q        <= 8'd0;
      byte_data_q <= 8'd0;
      byte_vld_q  <= 1'b0;
      long_q      <= 1'b0;
      crcen_q     <= 1'b0;
      timeout_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ncr_q       <= ncr_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      byte_data_q <= byte_data_d;
      byte_vld_q  <= byte_vld_d;
      long_q      <= long_d;
      crcen_q     <= crcen_d;
      timeout_q   <= timeout_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rsp_done  = (state_q == ST_FINISH);
  assign bus.byte_data = byte_data_q;
  assign bus.byte_vld  = byte_vld_q;
  assign bus.timeout   = timeout_q;
  assign bus.crc_err   = crc_err_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_mmc_rsp_rx.sv
// Bench for mmc_rsp_rx: table of response frames checked through a byte scoreboard,
// plus timeout, busy-start and mid-frame reset sequences.
module tb_mmc_rsp_rx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmc_rsp_rx_if bus ();
  mmc_rsp_rx #(.NCR_MAX(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string        name;
    logic         long_rsp;
    logic         crc_en;
    logic         mid_start;
    logic [135:0] frame;
    logic         exp_crc;
    logic         exp_frm;
  } vec_t;

  vec_t       tbl [7];
  logic [7:0] exp_q [$];
  int         n_cmp = 0, n_err = 0;
  int         byte_cnt = 0, done_cnt = 0;
  logic       st_crc, st_frm, st_to;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bench-side CRC7 model over frame bits hi..8
  function automatic logic [135:0] with_crc(logic [135:0] f, logic lng);
    logic [6:0] c = 7'h00;
    logic       fb;
    int         hi = lng ? 127 : 47;
    for (int i = hi; i >= 8; i--) begin
      fb = c[6] ^ f[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    f[7:1] = c;
    return f;
  endfunction

  always @(negedge clk) begin
    if (bus.byte_vld) begin
      byte_cnt++;
      if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, bus.byte_data}, 32'hFFFF_FFFF);
      else chk("byte_data", {24'd0, bus.byte_data}, {24'd0, exp_q.pop_front()});
    end
    if (bus.rsp_done) begin
      done_cnt++;
      st_crc = bus.crc_err;
      st_frm = bus.frame_err;
      st_to  = bus.timeout;
    end
  end

  task automatic strobe(logic b);
    bus.cmd_i = b;
    bus.bit_strobe = 1'b1;
    tick();
    bus.bit_strobe = 1'b0;
  endtask

  task automatic run_frame(vec_t v);
    int nb = v.long_rsp ? 136 : 48;
    int d0, b0, k;
    logic [7:0] bt;
    bus.long_rsp = v.long_rsp;
    bus.crc_en   = v.crc_en;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({v.name, "_busy"}, {31'd0, bus.busy}, 32'd1);
    d0 = done_cnt;
    b0 = byte_cnt;
    strobe(1'b1); tick();
    strobe(1'b1); tick();
    for (int i = nb - 1; i >= 0; i--) begin
      if ((nb - i) % 8 == 0) begin
        bt = v.frame[i +: 8];
        exp_q.push_back(bt);
      end
      if (v.mid_start && i == nb - 20) bus.start = 1'b1;
      strobe(v.frame[i]);
      bus.start = 1'b0;
      if (i > 0) tick();
    end
    // now in the FINISH cycle: a start here must be ignored
    if (v.mid_start) bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 10) begin tick(); k++; end
    chk({v.name, "_done"}, done_cnt - d0, 1);
    chk({v.name, "_nbytes"}, byte_cnt - b0, nb / 8);
    chk({v.name, "_crc_err"}, {31'd0, st_crc}, {31'd0, v.exp_crc});
    chk({v.name, "_frame_err"}, {31'd0, st_frm}, {31'd0, v.exp_frm});
    chk({v.name, "_timeout"}, {31'd0, st_to}, 32'd0);
    repeat (4) tick();
    chk({v.name, "_no_extra"}, done_cnt - d0, 1);
    chk({v.name, "_idle"}, {31'd0, bus.busy}, 32'd0);
    chk({v.name, "_q_empty"}, exp_q.size(), 0);
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({nm, "_byte_data"}, {24'd0, bus.byte_data}, 32'd0);
    chk({nm, "_byte_vld"}, {31'd0, bus.byte_vld}, 32'd0);
    chk({nm, "_rsp_done"}, {31'd0, bus.rsp_done}, 32'd0);
    chk({nm, "_timeout"}, {31'd0, bus.timeout}, 32'd0);
    chk({nm, "_crc_err"}, {31'd0, bus.crc_err}, 32'd0);
    chk({nm, "_frame_err"}, {31'd0, bus.frame_err}, 32'd0);
  endtask

  initial begin
    logic [135:0] lf;
    int b0;
    tbl[0] = '{"r7_ok",    1'b0, 1'b1, 1'b0, {88'd0, 48'h08_0000_01AA_13}, 1'b0, 1'b0};
    tbl[1] = '{"r7_crc",   1'b0, 1'b1, 1'b0, {88'd0, 48'h08_0000_01AA_15}, 1'b1, 1'b0};
    tbl[2] = '{"r7_end0",  1'b0, 1'b1, 1'b0, {88'd0, 48'h08_0000_01AA_12}, 1'b0, 1'b1};
    lf = with_crc({8'h3F, 120'h1D41444D534443313000123456789A, 8'h01}, 1'b1);
    tbl[3] = '{"r2_ok",    1'b1, 1'b1, 1'b0, lf, 1'b0, 1'b0};
    lf[60] = ~lf[60];
    tbl[4] = '{"r2_crc",   1'b1, 1'b1, 1'b0, lf, 1'b1, 1'b0};
    tbl[5] = '{"r3_nocrc", 1'b0, 1'b0, 1'b1, {88'd0, 48'h3F_80FF_8000_FF}, 1'b0, 1'b0};
    tbl[6] = '{"tx_bit1",  1'b0, 1'b1, 1'b0,
               with_crc({88'd0, 48'h48_1234_5678_01}, 1'b0), 1'b0, 1'b1};

    bus.start = 1'b0; bus.long_rsp = 1'b0; bus.crc_en = 1'b0;
    bus.bit_strobe = 1'b0; bus.cmd_i = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk_reset_vals("reset");

    for (int i = 0; i < 7; i++) run_frame(tbl[i]);

    // timeout: CMD held high for NCR_MAX strobes
    b0 = byte_cnt;
    bus.long_rsp = 1'b0; bus.crc_en = 1'b1;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      strobe(1'b1);
      if (i == 63) chk("to_early", {30'd0, bus.busy, bus.rsp_done}, 32'd2);
      if (i == 64) chk("to_done", {30'd0, bus.rsp_done, bus.timeout}, 32'd3);
      tick();
    end
    chk("to_idle", {31'd0, bus.busy}, 32'd0);
    chk("to_nobytes", byte_cnt - b0, 0);

    // reset mid-RECV after 20 bits, then a clean frame
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    strobe(1'b1); tick();
    for (int i = 47; i >= 28; i--) begin
      if ((48 - i) % 8 == 0) exp_q.push_back(tbl[0].frame[i +: 8]);
      strobe(tbl[0].frame[i]);
      tick();
    end
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset_vals("midrst");
    chk("midrst_q", exp_q.size(), 0);
    run_frame(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
